// File: rtl/regfile_op_sequencer.sv
// Register-file operation sequencer: arbitrates core/debug requests and steps LOAD, PUSH, POP and INCDEC
// through the register-file controls. Optional `define MEM_TIMEOUT_EN adds a memory-ack watchdog.
module regfile_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       C_VALID,
  output logic       C_READY,
  input  logic [1:0] C_OP,
  input  logic [3:0] C_RA,
  input  logic [3:0] C_RB,
  input  logic       C_DIR,
  input  logic       D_VALID,
  output logic       D_READY,
  input  logic [1:0] D_OP,
  input  logic [3:0] D_RA,
  input  logic [3:0] D_RB,
  input  logic       D_DIR,
  output logic       DONE,
  output logic       DONE_SRC,
  output logic       ILLEGAL,
  output logic       MEM_REQ,
  output logic       MEM_WE,
  input  logic       MEM_ACK,
  output logic [3:0] REGAX,
  output logic [3:0] REGBX,
  output logic       REGAOPX,
  output logic [1:0] REGBOPX,
  output logic       TIMEOUT
);

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_MEM, S_INC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_INCDEC = 2'b11} op_t;

  state_t     state, state_n;
  op_t        op_q, sel_op;
  logic [3:0] ra_q, rb_q, sel_ra, sel_rb, regax_q, regbx_q;
  logic       dir_q, src_q, sel_dir, prefer_d;
  logic       grant_d, accept, illegal_req, mem_expired;

  // Round-robin: on contention the debug port wins only if the core was granted last.
  always_comb begin
    grant_d     = D_VALID && (!C_VALID || prefer_d);
    accept      = (state == S_IDLE) && (C_VALID || D_VALID);
    sel_op      = grant_d ? op_t'(D_OP) : op_t'(C_OP);
    sel_ra      = grant_d ? D_RA : C_RA;
    sel_rb      = grant_d ? D_RB : C_RB;
    sel_dir     = grant_d ? D_DIR : C_DIR;
    illegal_req = (sel_ra == 4'hF) || (sel_rb == 4'hF) ||
                  (((sel_op == OP_PUSH) || (sel_op == OP_POP)) && (sel_ra == sel_rb));
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] mem_cnt;

  // Counts cycles spent in MEM; any exit passes through a non-MEM cycle, which clears it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) mem_cnt <= '0;
    else       mem_cnt <= (state == S_MEM) ? mem_cnt + 1'b1 : '0;
  end

  assign mem_expired = (state == S_MEM) && !MEM_ACK && (mem_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign mem_expired = 1'b0;
`endif

  always_comb begin
    // NOTE: every output and next-state gets a default first so no path infers a latch.
    state_n  = state;
    C_READY  = 1'b0;
    D_READY  = 1'b0;
    ILLEGAL  = 1'b0;
    DONE     = 1'b0;
    DONE_SRC = 1'b0;
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    REGAX    = regax_q;
    REGBX    = regbx_q;
    REGAOPX  = 1'b0;
    REGBOPX  = 2'b00;
    TIMEOUT  = 1'b0;
    unique case (state)
      S_IDLE: if (accept) begin
        C_READY = !grant_d;
        D_READY = grant_d;
        ILLEGAL = illegal_req;
        if (!illegal_req) begin
          unique case (sel_op)
            OP_PUSH: state_n = S_DEC;
            OP_POP:  state_n = S_MEM;
            default: state_n = S_DONE;
          endcase
        end
      end
      S_DEC: begin
        REGBX   = rb_q;
        REGBOPX = 2'b01;
        state_n = S_MEM;
      end
      S_MEM: begin
        REGAX   = ra_q;
        REGBX   = rb_q;
        MEM_REQ = 1'b1;
        MEM_WE  = (op_q == OP_PUSH);
        if (MEM_ACK) begin
          REGAOPX = (op_q == OP_POP);
          state_n = (op_q == OP_POP) ? S_INC : S_DONE;
        end else if (mem_expired) begin
          TIMEOUT  = 1'b1;
          DONE     = 1'b1;
          DONE_SRC = src_q;
          state_n  = S_IDLE;
        end
      end
      S_INC: begin
        REGBX   = rb_q;
        REGBOPX = 2'b11;
        state_n = S_DONE;
      end
      S_DONE: begin
        DONE     = 1'b1;
        DONE_SRC = src_q;
        state_n  = S_IDLE;
        if (op_q == OP_LOAD) begin
          REGAX   = ra_q;
          REGAOPX = 1'b1;
        end else if (op_q == OP_INCDEC) begin
          REGBX   = rb_q;
          REGBOPX = dir_q ? 2'b11 : 2'b01;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reset clears state, so MEM_REQ (decoded from state) drops without waiting for a clock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      op_q     <= OP_LOAD;
      ra_q     <= 4'h0;
      rb_q     <= 4'h0;
      dir_q    <= 1'b0;
      src_q    <= 1'b0;
      prefer_d <= 1'b0;
      regax_q  <= 4'h0;
      regbx_q  <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_n;
      regax_q <= REGAX;
      regbx_q <= REGBX;
      if (accept) begin
        op_q     <= sel_op;
        ra_q     <= sel_ra;
        rb_q     <= sel_rb;
        dir_q    <= sel_dir;
        src_q    <= grant_d;
        prefer_d <= !grant_d;
      end
    end
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Sequences multi-cycle register-file operations (LOAD, PUSH, POP, INC/DEC) on the 16-entry register file.
- Arbitrates between two requesters: the core instruction decoder (port C) and the debug port (port D).
- Drives the register file's REGAX/REGBX/REGAOPX/REGBOPX controls and a memory request handshake for stack traffic.
- r15 (PC) is owned by the register file and is never targeted by this block.

Parameters:
TIMEOUT_CYCLES, 255, memory-ack watchdog limit in cycles (only used with MEM_TIMEOUT_EN)

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
C_VALID  in  1  core request valid
C_READY  out  1  core request accepted this cycle
C_OP  in  2  00 LOAD, 01 PUSH, 10 POP, 11 INCDEC
C_RA  in  4  data register (LOAD/POP destination, PUSH source)
C_RB  in  4  stack pointer register (PUSH/POP) or INCDEC target
C_DIR  in  1  INCDEC direction: 1 increment, 0 decrement
D_VALID, D_READY, D_OP, D_RA, D_RB, D_DIR  same as C_* for the debug port
DONE  out  1  one-cycle pulse when an operation retires
DONE_SRC  out  1  0 core, 1 debug; valid with DONE
ILLEGAL  out  1  one-cycle pulse on a rejected request
MEM_REQ  out  1  memory access request; address is register-file DOUT_B
MEM_WE  out  1  1 write (PUSH, data is DOUT_A), 0 read (POP)
MEM_ACK  in  1  memory completes access this cycle
REGAX  out  4  register-file port-A select
REGBX  out  4  register-file port-B select
REGAOPX  out  1  1 = load DIN into REGAX this cycle
REGBOPX  out  2  11 increment REGBX, 01 decrement REGBX, x0 no inc/dec
TIMEOUT  out  1  one-cycle pulse on watchdog expiry (MEM_TIMEOUT_EN only)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours core.
- States: IDLE, DEC, MEM, INC, DONE.
- IDLE, arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last wins; after reset the core wins.
  - READY pulses for one cycle on the winner only. Operands (op, RA, RB, DIR, source) are latched on that cycle.
- Illegal request: RA=15 or RB=15, or RA==RB for PUSH/POP.
  - Accepted (READY=1) with ILLEGAL pulsed the same cycle.
  - No register or memory activity; remains IDLE; no DONE.
- LOAD: IDLE -> DONE. During the DONE cycle: REGAX=RA, REGAOPX=1. DONE pulses that cycle. Latency 1 cycle after accept.
- INCDEC: IDLE -> DONE. During the DONE cycle: REGBX=RB, REGBOPX=DIR?11:01, DONE=1.
- PUSH:
  - IDLE -> DEC: REGBX=RB, REGBOPX=01.
  - DEC -> MEM: REGAX=RA, REGBX=RB, MEM_REQ=1, MEM_WE=1, held until MEM_ACK.
  - MEM_ACK -> DONE.
  - Pre-decrement stack; minimum latency 3 cycles after accept.
- POP:
  - IDLE -> MEM: REGAX=RA, REGBX=RB, MEM_REQ=1, MEM_WE=0.
  - On the MEM_ACK cycle, REGAOPX=1 (memory data on DIN loads RA).
  - MEM_ACK -> INC: REGBX=RB, REGBOPX=11.
  - INC -> DONE. Post-increment stack; minimum latency 3 cycles.
- DONE state: one cycle, DONE=1, DONE_SRC=latched source, then IDLE. No accept is possible during DONE, so the maximum rate is one op per 2 cycles (LOAD/INCDEC).
- Outside the states listed, REGAOPX=0 and REGBOPX=00. REGAX/REGBX hold their last values.
- MEM_ACK while not in MEM: ignored.
- MEM_ACK in the same cycle MEM_REQ first rises: valid, and the transfer completes.
- Stack pointer wrap: register-file arithmetic wraps modulo 2^16; the sequencer does not check it.
- RESET mid-operation: immediate return to IDLE; MEM_REQ drops asynchronously; no DONE; partial SP update is not undone.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider counter runs while in MEM.
  - If MEM_ACK is absent for TIMEOUT_CYCLES consecutive cycles: drop MEM_REQ, pulse TIMEOUT and DONE, go to IDLE.
  - POP: no load and no SP increment.
  - PUSH: SP remains decremented.
- Undefined: MEM waits indefinitely; TIMEOUT is tied to 0.

Test Plan:
- C LOAD RA=3 -> 1 cycle after READY: REGAX=3, REGAOPX=1, DONE=1, DONE_SRC=0.
- C PUSH RA=2 RB=14, MEM_ACK 2 cycles after MEM_REQ -> sequence: REGBOPX=01 on RB=14; MEM_REQ/MEM_WE=1 for 2 cycles; DONE 1 cycle later.
- D POP RA=5 RB=13, immediate MEM_ACK -> REGAOPX=1 with REGAX=5 on the ack cycle; next cycle REGBOPX=11 on RB=13; then DONE, DONE_SRC=1.
- C and D valid together for 3 back-to-back ops -> grants C, D, C; each READY is a single-cycle pulse.
- C PUSH RB=15, and C POP RA=RB=4 -> ILLEGAL pulses, no MEM_REQ, no DONE, and REGAOPX/REGBOPX stay idle.
- RESET asserted in MEM of a POP -> MEM_REQ=0 immediately; state IDLE; no DONE. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> TIMEOUT and DONE 4 cycles into MEM.
